// File: rtl/mux_scan_n.sv
// mux_scan_n: registered N-channel multiplexer with manual select and
// automatic round-robin scanning over an enable mask.
//
// Parameters
//   N_CH   number of input channels (2..64)
//   WIDTH  bits per channel
//   DWELL  clock cycles spent on each channel in auto mode (>=2)
//   SEL_W  channel index width, derived from N_CH
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in         packed channel data, channel k at [k*WIDTH +: WIDTH]
//   mode       0 = manual select via sel_in, 1 = auto scan
//   sel_in     requested channel in manual mode
//   ch_en      per-channel enable mask
//   out        registered data of the current channel
//   sel_out    current channel index
//   ch_switch  one-cycle pulse coinciding with a new sel_out value
//   out_valid  registered enable bit of the channel loaded into out
module mux_scan_n #(
  parameter int N_CH  = 8,
  parameter int WIDTH = 1,
  parameter int DWELL = 500,
  localparam int SEL_W = $clog2(N_CH)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_CH*WIDTH-1:0] in,
  input  logic                  mode,
  input  logic [SEL_W-1:0]      sel_in,
  input  logic [N_CH-1:0]       ch_en,
  output logic [WIDTH-1:0]      out,
  output logic [SEL_W-1:0]      sel_out,
  output logic                  ch_switch,
  output logic                  out_valid
);

  localparam int CNT_W = $clog2(DWELL);

  logic [SEL_W-1:0] sel_cur;
  logic [SEL_W-1:0] sel_nxt;
  logic [SEL_W-1:0] sel_adv;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;
  logic             mode_q;
  logic             primed;
  logic [WIDTH-1:0] din;
  logic             en_cur;
  logic             req_ok;
  logic             any_en;

  // Current-channel data and enable, decoded with constant indices so that
  // non-power-of-two N_CH never produces an out-of-range select.
  always_comb begin
    din    = '0;
    en_cur = 1'b0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (sel_cur == SEL_W'(k)) begin
        din    = in[k*WIDTH +: WIDTH];
        en_cur = ch_en[k];
      end
    end
  end

  // A manual request is accepted only for an existing, enabled channel;
  // indices >= N_CH never match any k.
  always_comb begin
    req_ok = 1'b0;
    for (int unsigned k = 0; k < N_CH; k++) begin
      if (sel_in == SEL_W'(k) && ch_en[k]) req_ok = 1'b1;
    end
  end

  assign any_en = |ch_en;

  // Next enabled channel in ascending order with wrap. Scanning downwards
  // leaves hi = lowest enabled channel above sel_cur and lo = lowest enabled
  // channel overall; lo is the wrap target. If sel_cur is the only enabled
  // channel, lo equals sel_cur and the advance re-selects it.
  always_comb begin
    logic [SEL_W-1:0] hi;
    logic [SEL_W-1:0] lo;
    logic             hi_found;
    logic             lo_found;
    hi       = '0;
    lo       = '0;
    hi_found = 1'b0;
    lo_found = 1'b0;
    for (int unsigned k = N_CH; k > 0; k--) begin
      if (ch_en[k-1]) begin
        lo       = SEL_W'(k-1);
        lo_found = 1'b1;
        if ((k - 1) > 32'(sel_cur)) begin
          hi       = SEL_W'(k-1);
          hi_found = 1'b1;
        end
      end
    end
    if (hi_found)      sel_adv = hi;
    else if (lo_found) sel_adv = lo;
    else               sel_adv = sel_cur;
  end

  // Selection / dwell control. The mode-change check is suppressed on the
  // first edge after reset because the previous mode is unknown there.
  always_comb begin
    sel_nxt = sel_cur;
    cnt_nxt = cnt;
    if (primed && (mode != mode_q)) begin
      cnt_nxt = '0;
    end else if (!mode) begin
      cnt_nxt = '0;
      if (req_ok) sel_nxt = sel_in;
    end else if (!any_en) begin
      // nothing to scan: hold channel and counter
    end else if (!en_cur || (cnt == CNT_W'(DWELL - 1))) begin
      sel_nxt = sel_adv;
      cnt_nxt = '0;
    end else begin
      cnt_nxt = cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_cur   <= '0;
      cnt       <= '0;
      out       <= '0;
      out_valid <= 1'b0;
      ch_switch <= 1'b0;
      mode_q    <= 1'b0;
      primed    <= 1'b0;
    end else begin
      sel_cur   <= sel_nxt;
      cnt       <= cnt_nxt;
      out       <= din;
      out_valid <= en_cur;
      ch_switch <= (sel_nxt != sel_cur);
      mode_q    <= mode;
      primed    <= 1'b1;
    end
  end

  assign sel_out = sel_cur;

endmodule

// File: tb/tb_mux_scan_n.sv
module tb_mux_scan_n;

  localparam int N_CH  = 8;
  localparam int WIDTH = 4;
  localparam int DWELL = 4;

  logic                  clk;
  logic                  rst_n;
  logic [N_CH*WIDTH-1:0] din;
  logic                  mode;
  logic [2:0]            sel_in;
  logic [N_CH-1:0]       ch_en;
  logic [WIDTH-1:0]      out;
  logic [2:0]            sel_out;
  logic                  ch_switch;
  logic                  out_valid;

  int npass  = 0;
  int ntotal = 0;

  mux_scan_n #(.N_CH(N_CH), .WIDTH(WIDTH), .DWELL(DWELL)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in        (din),
    .mode      (mode),
    .sel_in    (sel_in),
    .ch_en     (ch_en),
    .out       (out),
    .sel_out   (sel_out),
    .ch_switch (ch_switch),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       mode;
    logic [2:0] sel_in;
    logic [7:0] en;
    logic [31:0] data;
    logic [2:0] e_sel;
    logic [3:0] e_out;
    logic       e_vld;
    logic       e_sw;
  } vec_t;

  vec_t tbl [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    ntotal++;
    if (act === req) npass++;
    else $display("FAIL %s: got %0h required %0h", name, act, req);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic reset_dut(input logic m, input logic [7:0] en, input logic [2:0] si);
    @(negedge clk);
    rst_n  = 1'b0;
    mode   = m;
    ch_en  = en;
    sel_in = si;
    din    = 32'h7654_3210;
    @(negedge clk);
    rst_n  = 1'b1;
  endtask

  initial begin
    int nsw;
    rst_n  = 1'b1;
    mode   = 1'b0;
    sel_in = '0;
    ch_en  = '1;
    din    = 32'h7654_3210;
    #2 rst_n = 1'b0;
    #1;
    check("rst_sel", sel_out, 0);
    check("rst_out", out, 0);
    check("rst_vld", out_valid, 0);
    check("rst_sw", ch_switch, 0);

    // manual-mode table; out lags by one cycle and reflects the old channel
    tbl[0]  = '{1'b0, 3'd2, 8'h0F, 32'h7654_3210, 3'd2, 4'h0, 1'b1, 1'b1};
    tbl[1]  = '{1'b0, 3'd2, 8'h0F, 32'h7654_3210, 3'd2, 4'h2, 1'b1, 1'b0};
    tbl[2]  = '{1'b0, 3'd5, 8'h0F, 32'h7654_3210, 3'd2, 4'h2, 1'b1, 1'b0};
    tbl[3]  = '{1'b0, 3'd3, 8'h0F, 32'h7654_3210, 3'd3, 4'h2, 1'b1, 1'b1};
    tbl[4]  = '{1'b0, 3'd3, 8'h0F, 32'h7654_A210, 3'd3, 4'hA, 1'b1, 1'b0};
    tbl[5]  = '{1'b0, 3'd3, 8'h0F, 32'h7654_5210, 3'd3, 4'h5, 1'b1, 1'b0};
    tbl[6]  = '{1'b0, 3'd3, 8'h00, 32'h7654_3210, 3'd3, 4'h3, 1'b0, 1'b0};
    tbl[7]  = '{1'b0, 3'd1, 8'h00, 32'h7654_3210, 3'd3, 4'h3, 1'b0, 1'b0};
    tbl[8]  = '{1'b0, 3'd0, 8'h0F, 32'h7654_3210, 3'd0, 4'h3, 1'b1, 1'b1};
    tbl[9]  = '{1'b0, 3'd7, 8'h80, 32'h7654_3210, 3'd7, 4'h0, 1'b0, 1'b1};
    tbl[10] = '{1'b0, 3'd7, 8'h80, 32'h7654_3210, 3'd7, 4'h7, 1'b1, 1'b0};

    reset_dut(1'b0, 8'hFF, 3'd0);
    tick();
    for (int i = 0; i < 11; i++) begin
      mode   = tbl[i].mode;
      sel_in = tbl[i].sel_in;
      ch_en  = tbl[i].en;
      din    = tbl[i].data;
      tick();
      check($sformatf("tbl%0d_sel", i), sel_out, tbl[i].e_sel);
      check($sformatf("tbl%0d_out", i), out, tbl[i].e_out);
      check($sformatf("tbl%0d_vld", i), out_valid, tbl[i].e_vld);
      check($sformatf("tbl%0d_sw", i), ch_switch, tbl[i].e_sw);
    end

    // auto walk over all channels
    reset_dut(1'b1, 8'hFF, 3'd0);
    nsw = 0;
    for (int e = 1; e <= 32; e++) begin
      tick();
      check($sformatf("walk_sel_e%0d", e), sel_out, (e / 4) % 8);
      check($sformatf("walk_sw_e%0d", e), ch_switch, (e % 4) == 0);
      if (ch_switch) nsw++;
    end
    check("walk_nsw", nsw, 8);

    // skip disabled channels and wrap 7 -> 0 in one dwell
    reset_dut(1'b1, 8'b1000_0101, 3'd0);
    for (int e = 1; e <= 12; e++) begin
      tick();
      check($sformatf("skip_sel_e%0d", e), sel_out,
            (e < 4) ? 0 : (e < 8) ? 2 : (e < 12) ? 7 : 0);
    end

    // drop the current channel at counter=1
    reset_dut(1'b1, 8'hFF, 3'd0);
    ticks(17);
    check("drop_pre_sel", sel_out, 4);
    ch_en = 8'hEF;
    tick();
    check("drop_sel", sel_out, 5);
    check("drop_sw", ch_switch, 1);
    ticks(3);
    check("drop_hold_sel", sel_out, 5);
    tick();
    check("drop_next_sel", sel_out, 6);

    // single enabled channel: ch 0 disabled at reset, then self re-select
    reset_dut(1'b1, 8'h08, 3'd0);
    tick();
    check("single_first_sel", sel_out, 3);
    check("single_first_sw", ch_switch, 1);
    check("single_first_vld", out_valid, 0);
    tick();
    check("single_vld", out_valid, 1);
    ticks(3);
    check("single_resel_sel", sel_out, 3);
    check("single_resel_sw", ch_switch, 0);

    // mode changes clear the counter and hold the channel on that edge
    reset_dut(1'b1, 8'hFF, 3'd0);
    ticks(2);
    mode   = 1'b0;
    sel_in = 3'd5;
    tick();
    check("mchg_man_sel", sel_out, 0);
    mode = 1'b1;
    tick();
    check("mchg_auto_sel", sel_out, 0);
    ticks(3);
    check("mchg_hold_sel", sel_out, 0);
    tick();
    check("mchg_adv_sel", sel_out, 1);

    // all channels disabled in auto: hold channel and counter
    reset_dut(1'b1, 8'hFF, 3'd0);
    ticks(2);
    ch_en = 8'h00;
    tick();
    check("zero_vld", out_valid, 0);
    ticks(2);
    check("zero_sel", sel_out, 0);
    ch_en = 8'hFF;
    tick();
    check("zero_resume_sel", sel_out, 0);
    tick();
    check("zero_adv_sel", sel_out, 1);
    check("zero_adv_sw", ch_switch, 1);

    // asynchronous reset right after a switch, between clock edges
    reset_dut(1'b1, 8'hFF, 3'd0);
    ticks(4);
    check("arst_pre_sw", ch_switch, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_sel", sel_out, 0);
    check("arst_out", out, 0);
    check("arst_vld", out_valid, 0);
    check("arst_sw", ch_switch, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int e = 1; e <= 4; e++) begin
      tick();
      check($sformatf("arst_rel_sel_e%0d", e), sel_out, (e == 4) ? 1 : 0);
      check($sformatf("arst_rel_sw_e%0d", e), ch_switch, e == 4);
    end

    $display("%0d/%0d checks passed", npass, ntotal);
    $finish;
  end

endmodule
